// File: rtl/cnn_stream_loader.sv
// rtl/cnn_stream_loader.sv - framed stream loader driving the CNN core write port and run handshake
module cnn_stream_loader #(
    parameter int DW      = 32,
    parameter int AW      = 16,
    parameter int SELW    = 5,
    parameter int H_IN    = 32,
    parameter int W_IN    = 32,
    parameter int CH_IN   = 3,
    parameter int SCALE   = 128,
    parameter int NORM_EN = 1,
    parameter int SEL_IMG = 0,
    parameter int TIMEOUT = 1 << 24
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [DW-1:0]   s_data,
    output logic            wr_en,
    output logic [SELW-1:0] wr_sel,
    output logic [AW-1:0]   wr_addr,
    output logic [DW-1:0]   wr_data,
    output logic            run_start,
    input  logic            run_done,
    input  logic [3:0]      pred_in,
    output logic            res_valid,
    output logic [3:0]      res_pred,
    output logic            busy,
    output logic            err
);

    localparam int              IMG_N    = H_IN * W_IN * CH_IN;
    localparam int              TW       = $clog2(TIMEOUT) + 1;
    localparam logic [SELW-1:0] SEL_GO   = '1;
    localparam logic [SELW-1:0] SEL_I    = SELW'(SEL_IMG);
    localparam logic [AW-1:0]   ONE_A    = 1;
    localparam logic [AW-1:0]   COL_LAST = AW'(W_IN - 1);
    localparam logic [AW-1:0]   ROW_LAST = AW'(H_IN - 1);
    localparam logic [AW-1:0]   CH_LAST  = AW'(CH_IN - 1);
    localparam logic [TW-1:0]   ONE_T    = 1;
    localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_RESULT} state_t;

    state_t          state, state_n;
    logic            rdy_q;
    logic [SELW-1:0] sel_q;
    logic [AW-1:0]   cnt_q, k_q, col_q, row_q, chn_q;
    logic [TW-1:0]   tmo_q;

    logic            accept;
    logic [SELW-1:0] hdr_sel;
    logic [AW-1:0]   hdr_cnt;
    logic            is_img, in_range;
    logic [AW-1:0]   img_addr;
    logic [7:0]      pix;
    logic [DW-1:0]   norm_data;

    assign s_ready  = rdy_q && (state == S_IDLE || state == S_LOAD);
    assign accept   = s_valid && s_ready;
    assign hdr_sel  = s_data[SELW-1:0];
    assign hdr_cnt  = s_data[16+AW-1:16];
    assign is_img   = (sel_q == SEL_I);
    // Image words past the frame size are swallowed without a write.
    assign in_range = !is_img || (32'(k_q) < 32'(IMG_N));
    // Planar payload position (ch, row, col) mapped to interleaved address.
    assign img_addr = AW'((32'(row_q) * 32'(W_IN) + 32'(col_q)) * 32'(CH_IN) + 32'(chn_q));
    assign pix      = (s_data > DW'(255)) ? 8'hFF : s_data[7:0];
    // Constant divisor keeps the result bit-exact to integer division.
    assign norm_data = DW'((32'(pix) * 32'(SCALE - 1) + 32'd127) / 32'd255);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    // Next-state decode and per-state strobes.
    always_comb begin
        state_n   = state;
        run_start = 1'b0;
        res_valid = 1'b0;
        busy      = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (hdr_sel == SEL_GO)  state_n = S_START;
                    else if (hdr_cnt != '0) state_n = S_LOAD;
                end
            end
            S_LOAD: begin
                if (accept && (k_q + ONE_A == cnt_q)) state_n = S_IDLE;
            end
            S_START: begin
                run_start = 1'b1;
                state_n   = S_WAIT;
            end
            S_WAIT: begin
                if (run_done)               state_n = S_RESULT;
                else if (tmo_q == TMO_LAST) state_n = S_IDLE;
            end
            S_RESULT: begin
                res_valid = 1'b1;
                state_n   = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Segment bookkeeping, registered write port, timeout counter and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q    <= 1'b0;
            sel_q    <= '0;
            cnt_q    <= '0;
            k_q      <= '0;
            col_q    <= '0;
            row_q    <= '0;
            chn_q    <= '0;
            tmo_q    <= '0;
            wr_en    <= 1'b0;
            wr_sel   <= '0;
            wr_addr  <= '0;
            wr_data  <= '0;
            res_pred <= '0;
            err      <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            wr_en <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        err <= 1'b0;
                        if (hdr_sel != SEL_GO) begin
                            sel_q <= hdr_sel;
                            cnt_q <= hdr_cnt;
                            k_q   <= '0;
                            col_q <= '0;
                            row_q <= '0;
                            chn_q <= '0;
                            if (hdr_sel == SEL_I && 32'(hdr_cnt) > 32'(IMG_N)) err <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        if (in_range) begin
                            wr_en   <= 1'b1;
                            wr_sel  <= sel_q;
                            wr_addr <= is_img ? img_addr : k_q;
                            wr_data <= (is_img && NORM_EN != 0) ? norm_data : s_data;
                        end
                        k_q <= k_q + ONE_A;
                        if (col_q == COL_LAST) begin
                            col_q <= '0;
                            if (row_q == ROW_LAST) begin
                                row_q <= '0;
                                chn_q <= (chn_q == CH_LAST) ? '0 : chn_q + ONE_A;
                            end else begin
                                row_q <= row_q + ONE_A;
                            end
                        end else begin
                            col_q <= col_q + ONE_A;
                        end
                    end
                end
                S_START: tmo_q <= '0;
                S_WAIT: begin
                    if (run_done)               res_pred <= pred_in;
                    else if (tmo_q == TMO_LAST) err <= 1'b1;
                    else                        tmo_q <= tmo_q + ONE_T;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_stream_loader.sv
// tb/tb_cnn_stream_loader.sv - scoreboard bench for cnn_stream_loader
module tb_cnn_stream_loader;

    typedef struct packed {
        logic [4:0]  sel;
        logic [15:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid, s_ready;
    logic [31:0] s_data;
    logic        wr_en;
    logic [4:0]  wr_sel;
    logic [15:0] wr_addr;
    logic [31:0] wr_data;
    logic        run_start, run_done, res_valid, busy, err;
    logic [3:0]  pred_in, res_pred;

    logic        t_valid, t_ready;
    logic [31:0] t_data;
    logic        t_wr_en;
    logic [4:0]  t_wr_sel;
    logic [15:0] t_wr_addr;
    logic [31:0] t_wr_data;
    logic        t_run_start, t_run_done, t_res_valid, t_busy, t_err;
    logic [3:0]  t_pred_in, t_res_pred;

    int checks = 0;
    int errors = 0;
    int nwr = 0, nstart = 0, nres = 0, t_nres = 0;
    wr_t exp_q[$];
    logic [3:0] res_q[$];
    wr_t e;
    logic [3:0] ep;

    always #5 clk = ~clk;

    cnn_stream_loader #(.TIMEOUT(64)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
        .run_start(run_start), .run_done(run_done), .pred_in(pred_in),
        .res_valid(res_valid), .res_pred(res_pred), .busy(busy), .err(err)
    );

    cnn_stream_loader #(.TIMEOUT(16)) dut_t (
        .clk(clk), .rst_n(rst_n), .s_valid(t_valid), .s_ready(t_ready), .s_data(t_data),
        .wr_en(t_wr_en), .wr_sel(t_wr_sel), .wr_addr(t_wr_addr), .wr_data(t_wr_data),
        .run_start(t_run_start), .run_done(t_run_done), .pred_in(t_pred_in),
        .res_valid(t_res_valid), .res_pred(t_res_pred), .busy(t_busy), .err(t_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic push(input logic [4:0] sel, input logic [15:0] addr, input logic [31:0] data);
        wr_t w;
        w.sel = sel; w.addr = addr; w.data = data;
        exp_q.push_back(w);
    endtask

    task automatic send(input logic [31:0] w);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data  = w;
        while (!s_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("s_ready_wait", {31'd0, s_ready}, 32'd1);
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic hdr(input logic [4:0] sel, input logic [15:0] cnt);
        send({cnt, 11'd0, sel});
    endtask

    function automatic logic [15:0] img_addr(input int i);
        int ch, r, c;
        ch = i / 1024;
        r  = (i / 32) % 32;
        c  = i % 32;
        return 16'(((r * 32) + c) * 3 + ch);
    endfunction

    // Monitor: every write and every result is matched against the scoreboard.
    always @(negedge clk) begin
        if (wr_en) begin
            nwr++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write sel=%0d addr=%0d data=%0d required=none", wr_sel, wr_addr, wr_data);
            end else begin
                e = exp_q.pop_front();
                if ({wr_sel, wr_addr, wr_data} !== {e.sel, e.addr, e.data}) begin
                    errors++;
                    $display("FAIL write actual=%0d/%0d/%0d required=%0d/%0d/%0d",
                             wr_sel, wr_addr, wr_data, e.sel, e.addr, e.data);
                end
            end
        end
        if (run_start) nstart++;
        if (t_res_valid) t_nres++;
        if (res_valid) begin
            nres++;
            checks++;
            if (res_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result actual=%0d required=none", res_pred);
            end else begin
                ep = res_q.pop_front();
                if (res_pred !== ep) begin
                    errors++;
                    $display("FAIL result actual=%0d required=%0d", res_pred, ep);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int n, n0, s0, r0;
        rst_n = 1'b0; s_valid = 1'b0; s_data = '0; run_done = 1'b0; pred_in = '0;
        t_valid = 1'b0; t_data = '0; t_run_done = 1'b0; t_pred_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
        chk("rst_wr", {wr_en, wr_sel, wr_addr}, 32'd0);
        chk("rst_wr_data", wr_data, 32'd0);
        chk("rst_ctl", {run_start, res_valid, res_pred, busy, err}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_rst", {31'd0, s_ready}, 32'd1);

        // Bias segment: 28 words, address equals data.
        hdr(5'd2, 16'd28);
        chk("hdr_no_write", {31'd0, wr_en}, 32'd0);
        chk("load_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 28; i++) begin
            push(5'd2, 16'(i), 32'(i));
            send(32'(i));
            if (i == 0) begin
                chk("first_wr_en", {31'd0, wr_en}, 32'd1);
                chk("first_wr_addr", {16'd0, wr_addr}, 32'd0);
            end
        end
        @(posedge clk); #1;
        chk("bias_idle_busy", {31'd0, busy}, 32'd0);
        chk("bias_idle_wr", {31'd0, wr_en}, 32'd0);

        // Gapped stream: writes follow valid with one cycle lag.
        hdr(5'd3, 16'd4);
        for (int i = 0; i < 4; i++) begin
            push(5'd3, 16'(i), 32'hA0 + 32'(i));
            send(32'hA0 + 32'(i));
            chk("gap_wr_on", {31'd0, wr_en}, 32'd1);
            @(posedge clk); #1;
            chk("gap_wr_off", {31'd0, wr_en}, 32'd0);
        end

        // Short image segment: normalisation points and interleaved stride.
        hdr(5'd0, 16'd3);
        push(5'd0, 16'd0, 32'd0);   send(32'd0);
        push(5'd0, 16'd3, 32'd64);  send(32'd128);
        push(5'd0, 16'd6, 32'd127); send(32'd300);

        // Full image of 255s.
        hdr(5'd0, 16'd3072);
        chk("img_err_clear", {31'd0, err}, 32'd0);
        for (int i = 0; i < 3072; i++) begin
            push(5'd0, img_addr(i), 32'd127);
            send(32'd255);
            if (i == 1025) chk("img_addr_c1r0c1", {16'd0, wr_addr}, 32'd4);
            if (i == 3071) chk("img_addr_last", {16'd0, wr_addr}, 32'd3071);
        end

        // Oversized image: error flagged, excess word dropped.
        @(posedge clk); #1;
        n0 = nwr;
        hdr(5'd0, 16'd3073);
        chk("oversize_err", {31'd0, err}, 32'd1);
        for (int i = 0; i < 3073; i++) begin
            if (i < 3072) push(5'd0, img_addr(i), 32'd127);
            send(32'd255);
        end
        repeat (2) @(posedge clk);
        #1;
        chk("oversize_writes", 32'(nwr - n0), 32'd3072);
        chk("oversize_idle", {30'd0, busy, err}, 32'd1);

        // Reset in the middle of a segment.
        hdr(5'd2, 16'd28);
        chk("hdr_clears_err", {31'd0, err}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            push(5'd2, 16'(i), 32'(i));
            send(32'(i));
        end
        s_valid = 1'b1; s_data = 32'd10;
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_wr", {wr_en, wr_sel, wr_addr}, 32'd0);
        chk("midrst_ctl", {s_ready, busy, err, wr_data[28:0]}, 32'd0);
        s_valid = 1'b0;
        @(posedge clk); #1;
        chk("midrst_hold", {s_ready, wr_en, busy}, 32'd0);
        chk("midrst_queue", 32'(exp_q.size()), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        hdr(5'd2, 16'd3);
        for (int i = 0; i < 3; i++) begin
            push(5'd2, 16'(i), 32'd200 + 32'(i));
            send(32'd200 + 32'(i));
        end
        @(posedge clk); #1;

        // GO with the core finishing 50 cycles later.
        res_q.push_back(4'd3);
        s0 = nstart; r0 = nres;
        send(32'h1F);
        chk("go_run_start", {31'd0, run_start}, 32'd1);
        chk("go_ready_low", {s_ready, busy}, 32'd1);
        @(posedge clk); #1;
        chk("go_start_once", {31'd0, run_start}, 32'd0);
        repeat (48) @(posedge clk);
        #1;
        chk("wait_busy", {31'd0, busy}, 32'd1);
        run_done = 1'b1; pred_in = 4'd3;
        n = 0;
        while (!res_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("res_valid_seen", {31'd0, res_valid}, 32'd1);
        run_done = 1'b0; pred_in = 4'd9;
        @(posedge clk); #1;
        chk("res_pulse_end", {30'd0, res_valid, busy}, 32'd0);
        chk("res_pred_held", {28'd0, res_pred}, 32'd3);
        chk("start_pulses", 32'(nstart - s0), 32'd1);
        chk("res_pulses", 32'(nres - r0), 32'd1);

        // Timeout on the TIMEOUT=16 instance.
        t_valid = 1'b1; t_data = 32'h1F;
        @(posedge clk); #1;
        t_valid = 1'b0;
        chk("t_run_start", {31'd0, t_run_start}, 32'd1);
        repeat (16) @(posedge clk);
        #1;
        chk("t_before_tmo", {30'd0, t_busy, t_err}, 32'd2);
        @(posedge clk); #1;
        chk("t_after_tmo", {30'd0, t_busy, t_err}, 32'd1);
        chk("t_no_result", 32'(t_nres), 32'd0);
        t_valid = 1'b1; t_data = {16'd0, 11'd0, 5'd1};
        @(posedge clk); #1;
        t_valid = 1'b0;
        chk("t_err_cleared", {31'd0, t_err}, 32'd0);

        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("wr_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("res_queue_empty", 32'(res_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cnn_stream_loader.md
# cnn_stream_loader

Hardware replacement for the file-driven weight/image load sequence of the CIFAR-10 inference core. Accepts a valid/ready word stream of framed segments, one header plus payload per segment. Each segment is written into the core's write port (`wr_en`/`wr_sel`/`wr_addr`/`wr_data`) at one word per cycle. Image segments are optionally normalised and reordered from planar to interleaved layout. A GO header launches inference, waits for `done`, and returns the predicted class with a timeout guard.

## Interface
Parameters:
- `DW`, 32: stream and write-data width
- `AW`, 16: write address width; header count field width is also AW (AW ≤ 16)
- `SELW`, 5: segment select width
- `H_IN`, 32: image rows
- `W_IN`, 32: image columns
- `CH_IN`, 3: image channels
- `SCALE`, 128: fixed-point scale for pixel normalisation
- `NORM_EN`, 1: 1 enables pixel normalisation on image segments
- `SEL_IMG`, 0: select code treated as image
- `TIMEOUT`, 2^24: maximum cycles to wait for `run_done`

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous active-low reset
- `s_valid`  in  1  stream word valid
- `s_ready`  out  1  loader can accept a word
- `s_data`  in  DW  header or payload word
- `wr_en`  out  1  write strobe to core
- `wr_sel`  out  SELW  target memory select
- `wr_addr`  out  AW  target address
- `wr_data`  out  DW  target data
- `run_start`  out  1  one-cycle start pulse to core
- `run_done`  in  1  core completion, level
- `pred_in`  in  4  core pred_index
- `res_valid`  out  1  one-cycle pulse with result
- `res_pred`  out  4  captured prediction, held
- `busy`  out  1  state ≠ IDLE
- `err`  out  1  sticky error; cleared on next accepted header

## Operation
Header word layout:
- `sel` = `s_data[SELW-1:0]`
- `count` = `s_data[16+AW-1:16]`
- `sel` all-ones is the GO command; its count field is ignored.

State machine (IDLE, LOAD, START, WAIT, RESULT):
- IDLE: `s_ready`=1.
  - Header with `sel`≠GO: latch `sel` and `count`, clear payload index `k`. Go to LOAD if `count`>0, otherwise stay in IDLE.
  - GO header: go to START.
- LOAD: `s_ready`=1. Each accepted word issues one write, then `k`++. The word accepted with `k`=`count`−1 returns to IDLE.
- START: `s_ready`=0, `run_start`=1 for exactly one cycle, clear timeout counter. Go to WAIT.
- WAIT: `s_ready`=0.
  - `run_done`=1: capture `res_pred`←`pred_in`, go to RESULT.
  - Counter reaches `TIMEOUT`−1 first: set `err`, go to IDLE with no `res_valid`.
- RESULT: `res_valid`=1 for one cycle, then IDLE.

Addressing:
- Non-image segments: `wr_addr` = `k`.
- Image segments: payload order is planar (channel outermost, then row, then column). `wr_addr` = ((r·W_IN)+c)·CH_IN + ch, with counters column c, row r, channel ch. Counters wrap c→0 at W_IN, r→0 at H_IN, ch→0 at CH_IN.
- Image `count` > H_IN·W_IN·CH_IN: set `err`; excess words are accepted and dropped (no write) until count is reached.

Normalisation (image segments with `NORM_EN`=1):
- p = `s_data` clamped to 0..255, treated as unsigned.
- `wr_data` = floor((p·(SCALE−1)+127)/255), zero-extended.
- Result must be bit-exact to integer division; a multiply-shift implementation is acceptable if exact over the input range.
- Otherwise `wr_data` = `s_data` unchanged.

## Timing
- Reset values: `s_ready`=0 during reset and 1 the cycle after release in IDLE. `wr_en`=0, `wr_sel`=0, `wr_addr`=0, `wr_data`=0, `run_start`=0, `res_valid`=0, `res_pred`=0, `busy`=0, `err`=0.
- Transfer happens on a rising edge with `s_valid`&&`s_ready`. The header costs one cycle; payload sustains 1 word/cycle.
- Write outputs are registered: a word accepted at edge n produces `wr_en`=1 with its sel/addr/data during cycle n+1. `wr_en`=0 in every cycle without an accepted payload word (gaps in `s_valid` produce gaps in `wr_en`).
- `run_start` is asserted the cycle after the GO header is accepted.
- `res_valid` is asserted the cycle after `run_done` is sampled high.
- `run_done` already high when entering WAIT counts as done at the first WAIT edge.
- `rst_n` low at any point, including mid-LOAD or WAIT, forces IDLE and all reset values immediately. No partial write is issued after reset.

## Test plan
- Bias segment: header sel=2, count=28, then values 0..27 -> 28 consecutive `wr_en` cycles, addr 0..27 = data, `wr_sel`=2; first write 1 cycle after first payload accept.
- Image segment: sel=0, count=3072, all payload =255 with ch index as marker -> `wr_data`=127 everywhere. Payload word for ch=1,r=0,c=1 writes addr 4; ch=2,r=31,c=31 writes addr 3071. Input 0 -> 0; input 128 -> 64; input 300 (clamped) -> 127.
- Gapped stream: `s_valid` toggled 1-0-1 during LOAD -> `wr_en` pattern follows with one-cycle lag, `k` is not advanced on idle cycles.
- GO with model `run_done` after 50 cycles, `pred_in`=3 -> `run_start` one pulse, `res_valid` one pulse, `res_pred`=3, `busy` drops after RESULT.
- Timeout with `TIMEOUT`=16 and `run_done` never asserted -> `err`=1 after 16 WAIT cycles, no `res_valid`, back to IDLE. Next header clears `err`.
- Reset asserted at payload word 10 of count=28 -> outputs are at reset values; a new header afterwards restarts at addr 0. Image count=3073 -> `err`=1, exactly 3072 writes.
